// File: rtl/cpu_defs.sv
// Shared CPU sizing defaults, reused by the decoder, ALU and register file.
package cpu_defs;
  localparam int CPU_DATA_W   = 16;
  localparam int CPU_NUM_REGS = 16;
  localparam int CPU_ADDR_W   = 4;
endpackage

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// Pending-load scoreboard: per-register pend bits, issue gating and count.
module reg_scoreboard
  import cpu_defs::*;
#(
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_issue_addr,
  output logic                ld_issue_ready,
  input  logic                wa_en,
  input  logic [ADDR_W-1:0]   wa_addr,
  input  logic                wb_fire,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] pend,
  output logic [ADDR_W:0]     pend_count
);

  logic [NUM_REGS-1:0] pend_n;
  logic [ADDR_W:0]     cnt_n;
  logic                r0_iss;
  logic                iss_fire;

  assign r0_iss = (ZERO_R0 != 0) && (ld_issue_addr == '0);
  assign ld_issue_ready = ~reset & (r0_iss | ~pend[ld_issue_addr]);
  assign iss_fire = ld_issue & ld_issue_ready & ~r0_iss;

  // A new issue outranks any clear landing on the same bit.
  always_comb begin
    pend_n = pend;
    cnt_n  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iss_fire && ld_issue_addr == ADDR_W'(i))
        pend_n[i] = 1'b1;
      else if ((wa_en && wa_addr == ADDR_W'(i)) ||
               (wb_fire && wb_addr == ADDR_W'(i)))
        pend_n[i] = 1'b0;
      cnt_n = cnt_n + {{ADDR_W{1'b0}}, pend_n[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      pend_count <= '0;
    end else begin
      pend       <= pend_n;
      pend_count <= cnt_n;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one shared write port (ALU first, load return second)
// and a pending-load scoreboard. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_scoreboard
  import cpu_defs::*;
#(
  parameter  int DATA_W   = CPU_DATA_W,
  parameter  int NUM_REGS = CPU_NUM_REGS,
  parameter  int ZERO_R0  = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_addr,
  output logic              ld_issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_a_busy,
  output logic              rd_b_busy,
  output logic [ADDR_W:0]   pend_count
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic                wa_we;
  logic                wb_fire;
  logic                wb_commit;
  logic [ADDR_W-1:0]   raddr [2];
  logic [DATA_W-1:0]   rdata [2];
  logic                rbusy [2];

  assign wa_we = wa_en & ~reset &
                 ~((ZERO_R0 != 0) && (wa_addr == '0));
  assign wb_ready  = ~reset & ~wa_en;
  assign wb_fire   = wb_valid & wb_ready;
  // Returns with no pend bit are stale and only acknowledged.
  assign wb_commit = wb_fire & pend[wb_addr];

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_R0  (ZERO_R0)
  ) u_sb (
    .clk            (clk),
    .reset          (reset),
    .ld_issue       (ld_issue),
    .ld_issue_addr  (ld_issue_addr),
    .ld_issue_ready (ld_issue_ready),
    .wa_en          (wa_en & ~reset),
    .wa_addr        (wa_addr),
    .wb_fire        (wb_fire),
    .wb_addr        (wb_addr),
    .pend           (pend),
    .pend_count     (pend_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wa_we) begin
      regs[wa_addr] <= wa_data;
    end else if (wb_commit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign raddr[0] = rd_a_addr;
  assign raddr[1] = rd_b_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata[p] = regs[raddr[p]];
      rbusy[p] = pend[raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wa_we && wa_addr == raddr[p]) begin
        rdata[p] = wa_data;
      end else if (wb_commit && wb_addr == raddr[p]) begin
        rdata[p] = wb_data;
        rbusy[p] = 1'b0;
      end
`endif
      if ((ZERO_R0 != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign rd_a_data = rdata[0];
  assign rd_b_data = rdata[1];
  assign rd_a_busy = rbusy[0];
  assign rd_b_busy = rbusy[1];

endmodule
